// File: rtl/bram_acc_pkg.sv
// rtl/bram_acc_pkg.sv - shared state encoding and width defaults for the BRAM write controller
package bram_acc_pkg;

  localparam int AWIDTH_DEF = 8;
  localparam int DWIDTH_DEF = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/counter_write.sv
// rtl/counter_write.sv - BRAM write address counter with increment and clear
module counter_write #(
  parameter int AWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              write_run_i,
  input  logic              write_done_i,
  output logic [AWIDTH-1:0] count_o
);

  logic [AWIDTH-1:0] count_q;
  logic [AWIDTH-1:0] count_d;

  // Advance after each accepted word, return to zero when the burst closes
  always_comb begin
    count_d = count_q;
    if (write_done_i) begin
      count_d = '0;
    end else if (write_run_i) begin
      count_d = count_q + AWIDTH'(1);
    end
  end

  // Count register, cleared asynchronously so an abandoned burst restarts at 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bram_write_ctrl.sv
// rtl/bram_write_ctrl.sv - streams a fixed-length burst of words into consecutive BRAM addresses
module bram_write_ctrl
  import bram_acc_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [AWIDTH-1:0] num_cnt_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DWIDTH-1:0] s_data_i,
  output logic [AWIDTH-1:0] addr_o,
  output logic              ce_o,
  output logic              we_o,
  output logic [DWIDTH-1:0] d_o,
  output logic              idle_o,
  output logic              run_o,
  output logic              done_o
);

  logic [1:0]        state_q, state_d;
  logic [AWIDTH-1:0] num_q, num_d;
  logic [AWIDTH-1:0] count;
  logic              handshake;
  logic              last_write;

  assign s_ready_o  = (state_q == ST_RUN);
  assign handshake  = s_valid_i & s_ready_o;
  // Only evaluated in RUN, where num_q is never zero, so the subtraction cannot underflow
  assign last_write = handshake && (count == AWIDTH'(num_q - AWIDTH'(1)));

  // Next state and burst-length latch; start is only honoured from IDLE
  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          num_d   = num_cnt_i;
          state_d = (num_cnt_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_write) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched length registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
    end
  end

  // Handshake never coincides with DONE, so increment and clear are exclusive
  counter_write #(
    .AWIDTH (AWIDTH)
  ) u_counter_write (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_run_i  (handshake),
    .write_done_i (state_q == ST_DONE),
    .count_o      (count)
  );

  assign addr_o = count;
  assign ce_o   = handshake;
  assign we_o   = handshake;
  assign d_o    = handshake ? s_data_i : '0;
  assign idle_o = (state_q == ST_IDLE);
  assign run_o  = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_bram_write_ctrl.sv
// tb/tb_bram_write_ctrl.sv - self-checking bench for bram_write_ctrl
module tb_bram_write_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] num_cnt_i = '0;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i = '0;
  logic [AW-1:0] addr_o;
  logic          ce_o, we_o;
  logic [DW-1:0] d_o;
  logic          idle_o, run_o, done_o;

  bram_write_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start_i   (start_i),
    .num_cnt_i (num_cnt_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_data_i  (s_data_i),
    .addr_o    (addr_o),
    .ce_o      (ce_o),
    .we_o      (we_o),
    .d_o       (d_o),
    .idle_o    (idle_o),
    .run_o     (run_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: words still owed in this burst, next address, and a one-cycle done flag
  int       m_rem = 0;
  int       m_addr = 0;
  bit       m_done = 1'b0;
  int       cyc = 0;
  int       done_cnt = 0;
  int       wr_addr[$];
  int       wr_cyc[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_rem = 0; m_addr = 0; m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0; m_addr = 0;
    end else if (m_rem > 0) begin
      if (s_valid_i) begin
        m_addr = m_addr + 1; m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1'b1;
      end
    end else if (start_i) begin
      if (num_cnt_i == 0) m_done = 1'b1;
      else m_rem = int'(num_cnt_i);
    end
  end

  always @(posedge clk) cyc++;

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    bit run_e, hs_e;
    run_e = (m_rem > 0);
    hs_e  = run_e && s_valid_i;
    chk("idle_o", 64'(idle_o), 64'(!run_e && !m_done));
    chk("run_o", 64'(run_o), 64'(run_e));
    chk("done_o", 64'(done_o), 64'(m_done));
    chk("s_ready_o", 64'(s_ready_o), 64'(run_e));
    chk("ce_o", 64'(ce_o), 64'(hs_e));
    chk("we_o", 64'(we_o), 64'(hs_e));
    chk("addr_o", 64'(addr_o), 64'(m_addr));
    chk("d_o", 64'(d_o), hs_e ? 64'(s_data_i) : 64'd0);
    if (we_o === 1'b1) begin
      wr_addr.push_back(int'(addr_o));
      wr_cyc.push_back(cyc);
    end
    if (done_o === 1'b1) done_cnt++;
  end

  task automatic step(input logic st, input logic [AW-1:0] n, input logic v);
    @(posedge clk); #1;
    start_i = st; num_cnt_i = n; s_valid_i = v; s_data_i = $urandom;
  endtask

  task automatic clear_log();
    wr_addr.delete(); wr_cyc.delete(); done_cnt = 0;
  endtask

  // Bounded wait for return to IDLE
  task automatic finish_burst(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0);
      @(negedge clk); #1;
      if (idle_o === 1'b1) begin ok = 1'b1; break; end
    end
    chk({nm, "_reach_idle"}, 64'(ok), 64'd1);
  endtask

  task automatic check_writes(input string nm, input int n, input int dones);
    chk({nm, "_write_count"}, 64'(wr_addr.size()), 64'(n));
    for (int i = 0; i < wr_addr.size() && i < n; i++)
      chk({nm, "_write_addr"}, 64'(wr_addr[i]), 64'(i));
    chk({nm, "_done_pulses"}, 64'(done_cnt), 64'(dones));
  endtask

  initial begin
    #23;
    @(negedge clk); #1;
    chk("rst_idle", 64'(idle_o), 64'd1);
    chk("rst_addr", 64'(addr_o), 64'd0);
    reset_n = 1'b1;

    // Four words back to back
    clear_log();
    step(1'b1, 8'd4, 1'b0);
    repeat (4) step(1'b0, 8'd0, 1'b1);
    finish_burst("s1");
    check_writes("s1", 4, 1);
    if (wr_cyc.size() == 4) begin
      chk("s1_consecutive", 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);
    end

    // Three words with valid gaps
    clear_log();
    step(1'b1, 8'd3, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    @(negedge clk); #1;
    chk("s2_run_before_done", 64'(run_o), 64'd1);
    step(1'b0, 8'd0, 1'b0);
    @(negedge clk); #1;
    chk("s2_done_after_third", 64'(done_o), 64'd1);
    finish_burst("s2");
    check_writes("s2", 3, 1);
    if (wr_cyc.size() == 3) begin
      chk("s2_gap_spacing", 64'(wr_cyc[2] - wr_cyc[0]), 64'd4);
    end

    // Zero-length burst
    clear_log();
    step(1'b1, 8'd0, 1'b1);
    @(negedge clk); #1;
    chk("s3_done_first_cycle", 64'(done_o), 64'd0);
    step(1'b0, 8'd0, 1'b1);
    @(negedge clk); #1;
    chk("s3_done_next_cycle", 64'(done_o), 64'd1);
    chk("s3_no_we", 64'(we_o), 64'd0);
    finish_burst("s3");
    check_writes("s3", 0, 1);

    // Start re-pulsed mid-burst with a different length
    clear_log();
    step(1'b1, 8'd5, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    step(1'b1, 8'd9, 1'b1);
    repeat (3) step(1'b0, 8'd9, 1'b1);
    finish_burst("s4");
    check_writes("s4", 5, 1);

    // Reset after two of six writes
    clear_log();
    step(1'b1, 8'd6, 1'b0);
    repeat (2) step(1'b0, 8'd0, 1'b1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("s5_rst_idle", 64'(idle_o), 64'd1);
    chk("s5_rst_run", 64'(run_o), 64'd0);
    chk("s5_rst_done", 64'(done_o), 64'd0);
    chk("s5_rst_ready", 64'(s_ready_o), 64'd0);
    chk("s5_rst_we", 64'(we_o), 64'd0);
    chk("s5_rst_ce", 64'(ce_o), 64'd0);
    chk("s5_rst_addr", 64'(addr_o), 64'd0);
    chk("s5_rst_d", 64'(d_o), 64'd0);
    check_writes("s5a", 2, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; s_valid_i = 1'b0;
    clear_log();
    step(1'b1, 8'd2, 1'b0);
    repeat (2) step(1'b0, 8'd0, 1'b1);
    finish_burst("s5b");
    check_writes("s5b", 2, 1);

    // Maximum length burst
    clear_log();
    step(1'b1, 8'd255, 1'b0);
    repeat (255) step(1'b0, 8'd0, 1'b1);
    finish_burst("s6");
    check_writes("s6", 255, 1);
    if (wr_cyc.size() == 255) begin
      chk("s6_last_addr", 64'(wr_addr[254]), 64'd254);
      chk("s6_throughput", 64'(wr_cyc[254] - wr_cyc[0]), 64'd254);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
